// File: rtl/array_arbiter_pkg.sv
// array_arbiter_pkg: shared FSM state and port identifiers for the array arbiter
package array_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant with a pointer that moves to the loser on contention
module rr_arb2
    import array_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    // Grant the favoured port on contention, otherwise pass the lone request through
    always_comb begin
        gnt_o = !en_i ? 2'b00 : (&req_i) ? ((ptr_q == PORT1) ? 2'b10 : 2'b01) : req_i;
        ptr_d = (en_i && (&req_i)) ? ~ptr_q : ptr_q;
    end

    // Pointer register, favouring port 0 out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= PORT0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/array_arbiter.sv
// array_arbiter: two-port round-robin access to a split read/write array with a flush sweep
module array_arbiter
    import array_arbiter_pkg::*;
#(
    parameter int s_index = 3,
    parameter int width   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [s_index-1:0] idx0,
    input  logic [s_index-1:0] idx1,
    input  logic [width-1:0]   wdata0,
    input  logic [width-1:0]   wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [width-1:0]   rdata0,
    output logic [width-1:0]   rdata1,
    input  logic               flush,
    output logic               flush_busy,
    output logic               flush_done,
    output logic               arr_read,
    output logic               arr_load,
    output logic [s_index-1:0] arr_rindex,
    output logic [s_index-1:0] arr_windex,
    output logic [width-1:0]   arr_datain,
    input  logic [width-1:0]   arr_dataout
);

    state_e             state_q, state_d;
    logic [s_index-1:0] cnt_q, cnt_d;
    logic               rvalid0_q, rvalid1_q, done_q;
    logic [width-1:0]   rdata0_q, rdata1_q, rd_val;
    logic [1:0]         rgnt, wgnt;
    logic               en, last;

    // Grants only in IDLE with no flush pending; reset also blocks the combinational grants
    assign en = rst && (state_q == IDLE) && !flush;

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en),
        .req_i ({req1 & ~we1, req0 & ~we0}),
        .gnt_o (rgnt)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en),
        .req_i ({req1 & we1, req0 & we0}),
        .gnt_o (wgnt)
    );

    // Array port steering, write-to-read forwarding and FSM next state
    always_comb begin
        last       = &cnt_q;
        gnt0       = rgnt[PORT0] | wgnt[PORT0];
        gnt1       = rgnt[PORT1] | wgnt[PORT1];
        arr_read   = |rgnt;
        arr_rindex = rgnt[PORT1] ? idx1 : idx0;
        arr_load   = (state_q == FLUSH) | (|wgnt);
        arr_windex = (state_q == FLUSH) ? cnt_q : (wgnt[PORT1] ? idx1 : idx0);
        arr_datain = (state_q == FLUSH) ? '0 : (wgnt[PORT1] ? wdata1 : wdata0);
        rd_val     = ((|wgnt) && (arr_windex == arr_rindex)) ? arr_datain : arr_dataout;
        state_d    = (state_q == IDLE) ? (flush ? FLUSH : IDLE) : (last ? IDLE : FLUSH);
        cnt_d      = (state_q == FLUSH && !last) ? cnt_q + 1'b1 : '0;
        flush_busy = (state_q == FLUSH);
        flush_done = done_q;
        rvalid0    = rvalid0_q;
        rvalid1    = rvalid1_q;
        rdata0     = rdata0_q;
        rdata1     = rdata1_q;
    end

    // FSM state and sweep counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered read responses and the flush completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            rvalid0_q <= rgnt[PORT0];
            rvalid1_q <= rgnt[PORT1];
            rdata0_q  <= rgnt[PORT0] ? rd_val : rdata0_q;
            rdata1_q  <= rgnt[PORT1] ? rd_val : rdata1_q;
            done_q    <= (state_q == FLUSH) && last;
        end
    end

endmodule

// File: tb/tb_array_arbiter.sv
// tb_array_arbiter: directed stimulus against a transaction-level model of the array arbiter
module tb_array_arbiter;

    localparam int SI = 3;
    localparam int W  = 1;
    localparam int NS = 8;
    localparam logic [NS-1:0] PRESET = 8'h0A;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0, req1, we0, we1, flush;
    logic [SI-1:0] idx0, idx1;
    logic [W-1:0]  wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, flush_busy, flush_done;
    logic [W-1:0]  rdata0, rdata1;
    logic          arr_read, arr_load;
    logic [SI-1:0] arr_rindex, arr_windex;
    logic [W-1:0]  arr_datain, arr_dataout;

    int passed = 0;
    int total  = 0;

    array_arbiter #(.s_index(SI), .width(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .idx0        (idx0),
        .idx1        (idx1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .flush       (flush),
        .flush_busy  (flush_busy),
        .flush_done  (flush_done),
        .arr_read    (arr_read),
        .arr_load    (arr_load),
        .arr_rindex  (arr_rindex),
        .arr_windex  (arr_windex),
        .arr_datain  (arr_datain),
        .arr_dataout (arr_dataout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Array emulator: combinational read port, clocked write port, preset contents at start-up
    logic [W-1:0] mem_arr [NS];
    logic         preset = 1'b1;
    assign arr_dataout = mem_arr[arr_rindex];
    always @(posedge clk) begin
        if (preset) for (int i = 0; i < NS; i++) mem_arr[i] <= W'(PRESET[i]);
        else if (arr_load) mem_arr[arr_windex] <= arr_datain;
    end

    // Transaction-level model: expected array contents, favoured port per access class
    logic [W-1:0] m_mem [NS];
    bit           m_flush, rst_seen;
    int           m_sweep, fav_r, fav_w, rport, wport, ridx, widx;
    bit           r0, r1, w0, w1, e_rd, e_ld, nrv0, nrv1, ndone;
    logic [W-1:0] wdat, v, exp_rd0, exp_rd1;
    bit           exp_rv0, exp_rv1, exp_done;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            if (rst_seen) begin
                chk("rst_gnt0", gnt0, 0);
                chk("rst_gnt1", gnt1, 0);
                chk("rst_rvalid0", rvalid0, 0);
                chk("rst_rvalid1", rvalid1, 0);
                chk("rst_busy", flush_busy, 0);
                chk("rst_done", flush_done, 0);
                chk("rst_rdata0", rdata0, 0);
                chk("rst_rdata1", rdata1, 0);
            end
            rst_seen = 1;
            m_flush  = 0;
            m_sweep  = 0;
            fav_r    = 0;
            fav_w    = 0;
            exp_rv0  = 0;
            exp_rv1  = 0;
            exp_rd0  = '0;
            exp_rd1  = '0;
            exp_done = 0;
            if (preset) for (int i = 0; i < NS; i++) m_mem[i] = W'(PRESET[i]);
        end else begin
            rst_seen = 0;
            chk("rvalid0", rvalid0, exp_rv0);
            chk("rvalid1", rvalid1, exp_rv1);
            chk("rdata0", rdata0, exp_rd0);
            chk("rdata1", rdata1, exp_rd1);
            chk("flush_busy", flush_busy, m_flush);
            chk("flush_done", flush_done, exp_done);
            e_rd = 0; e_ld = 0; nrv0 = 0; nrv1 = 0; ndone = 0;
            rport = 0; wport = 0; ridx = 0; widx = 0; wdat = '0;
            if (m_flush) begin
                e_ld = 1;
                widx = m_sweep;
                m_mem[m_sweep] = '0;
                if (m_sweep == NS - 1) begin
                    m_flush = 0;
                    m_sweep = 0;
                    ndone   = 1;
                end else m_sweep++;
            end else if (flush) begin
                m_flush = 1;
                m_sweep = 0;
            end else begin
                r0 = req0 && !we0; r1 = req1 && !we1;
                w0 = req0 && we0;  w1 = req1 && we1;
                if (r0 || r1) begin
                    rport = (r0 && r1) ? fav_r : (r1 ? 1 : 0);
                    if (r0 && r1) fav_r = 1 - rport;
                    e_rd = 1;
                    ridx = rport ? idx1 : idx0;
                end
                if (w0 || w1) begin
                    wport = (w0 && w1) ? fav_w : (w1 ? 1 : 0);
                    if (w0 && w1) fav_w = 1 - wport;
                    e_ld = 1;
                    widx = wport ? idx1 : idx0;
                    wdat = wport ? wdata1 : wdata0;
                end
                if (e_rd) begin
                    v = (e_ld && widx == ridx) ? wdat : m_mem[ridx];
                    if (rport == 0) begin exp_rd0 = v; nrv0 = 1; end
                    else begin exp_rd1 = v; nrv1 = 1; end
                end
                if (e_ld) m_mem[widx] = wdat;
            end
            chk("gnt0", gnt0, (e_rd && rport == 0) || (e_ld && wport == 0 && !m_flush && widx == (wport ? idx1 : idx0)) ? 1 : 0);
            chk("gnt1", gnt1, (e_rd && rport == 1) || (e_ld && wport == 1) ? 1 : 0);
            chk("arr_read", arr_read, e_rd);
            chk("arr_load", arr_load, e_ld);
            if (e_rd) chk("arr_rindex", arr_rindex, ridx);
            if (e_ld) begin
                chk("arr_windex", arr_windex, widx);
                chk("arr_datain", arr_datain, wdat);
            end
            exp_rv0  = nrv0;
            exp_rv1  = nrv1;
            exp_done = ndone;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int dones, n;

    initial begin
        {req0, req1, we0, we1, flush} = '0;
        idx0 = '0; idx1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        @(negedge clk);
        chk("lit_rst_busy", flush_busy, 0);
        chk("lit_rst_rdata0", rdata0, 0);
        tick();
        rst = 1'b1;
        // Both ports read after reset: winners 0,1,0
        req0 = 1; req1 = 1; idx0 = 1; idx1 = 2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("c2_gnt0_%0d", c), gnt0, (c == 1) ? 0 : 1);
            chk($sformatf("c2_gnt1_%0d", c), gnt1, (c == 1) ? 1 : 0);
            tick();
        end
        req0 = 0; req1 = 0;
        tick();
        // Single read of a preset entry
        req0 = 1; we0 = 0; idx0 = 3;
        @(negedge clk);
        chk("c1_gnt0", gnt0, 1);
        tick();
        req0 = 0;
        @(negedge clk);
        chk("c1_rvalid0", rvalid0, 1);
        chk("c1_rdata0", rdata0, 1);
        tick();
        // Read and write to the same set in one cycle, read sees the write data
        req0 = 1; we0 = 1; idx0 = 5; wdata0 = 1;
        req1 = 1; we1 = 0; idx1 = 5;
        @(negedge clk);
        chk("c3_gnt0", gnt0, 1);
        chk("c3_gnt1", gnt1, 1);
        tick();
        req0 = 0; req1 = 0; we0 = 0;
        @(negedge clk);
        chk("c3_rvalid1", rvalid1, 1);
        chk("c3_rdata1", rdata1, 1);
        tick();
        // Both ports write set 0: one strobe per cycle, alternating winners
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; idx0 = 0; idx1 = 0; wdata0 = 1; wdata1 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("c6_gnt0_%0d", c), gnt0, (c % 2 == 0) ? 1 : 0);
            chk($sformatf("c6_gnt1_%0d", c), gnt1, (c % 2 == 1) ? 1 : 0);
            chk($sformatf("c6_load_%0d", c), arr_load, 1);
            tick();
        end
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        tick();
        // Flush sweep with port 1 read held throughout; a repeated flush is ignored
        flush = 1; req1 = 1; idx1 = 3;
        @(negedge clk);
        chk("c4_gnt1_req_cycle", gnt1, 0);
        tick();
        flush = 0;
        dones = 0;
        for (int c = 0; c < NS; c++) begin
            @(negedge clk);
            chk($sformatf("c4_busy_%0d", c), flush_busy, 1);
            chk($sformatf("c4_windex_%0d", c), arr_windex, c);
            chk($sformatf("c4_datain_%0d", c), arr_datain, 0);
            dones += int'(flush_done);
            tick();
            if (c == 2) flush = 1;
            if (c == 4) flush = 0;
        end
        @(negedge clk);
        chk("c4_done", flush_done, 1);
        chk("c4_busy_end", flush_busy, 0);
        chk("c4_gnt1_first_idle", gnt1, 1);
        dones += int'(flush_done);
        tick();
        req1 = 0;
        @(negedge clk);
        dones += int'(flush_done);
        chk("c4_done_count", dones, 1);
        chk("c4_rdata1_zeroed", rdata1, 0);
        tick();
        // Reset in the middle of a sweep
        flush = 1;
        tick();
        flush = 0;
        repeat (4) tick();
        rst = 0;
        @(negedge clk);
        chk("c5_busy_in_rst", flush_busy, 0);
        tick();
        rst = 1;
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dones += int'(flush_done);
            tick();
        end
        chk("c5_no_done", dones, 0);
        flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        chk("c5_restart_windex", arr_windex, 0);
        n = 0;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            tick();
            @(negedge clk);
            if (flush_done) n = c;
        end
        chk("c5_flush_len", n, NS);
        tick();
        // Reset drops a read response granted just before it
        req0 = 1; we0 = 0; idx0 = 1;
        @(negedge clk);
        chk("rd_drop_gnt0", gnt0, 1);
        #1 rst = 0;
        @(posedge clk);
        #1 rst = 1;
        req0 = 0;
        @(negedge clk);
        chk("rd_drop_rvalid0", rvalid0, 0);
        chk("rd_drop_rdata0", rdata0, 0);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
